// File: rtl/recepcao_face_serial_if.sv
// Byte-in / pixel-read bundle between the UART side, the face reader and the face buffer.
// The master drives the byte strobe, libera and read address; the slave returns pixel data and status.
interface recepcao_face_serial_if;
    logic        byte_valido;
    logic [7:0]  dado_rx;
    logic        libera;
    logic [1:0]  addr_linha;
    logic [1:0]  addr_coluna;
    logic [15:0] q;
    logic        face_pronta;
    logic        erro;
    logic [2:0]  db_estado;

    modport master (
        output byte_valido, dado_rx, libera, addr_linha, addr_coluna,
        input  q, face_pronta, erro, db_estado
    );

    modport slave (
        input  byte_valido, dado_rx, libera, addr_linha, addr_coluna,
        output q, face_pronta, erro, db_estado
    );
endinterface

// File: rtl/recepcao_face_serial.sv
// Assembles 18 big-endian bytes into a 3x3 buffer of 16-bit pixels; RECEPCAO_CHECKSUM_EN adds a trailing XOR byte check.
// Read data is registered (1 cycle); there is no backpressure, so bytes arriving while a face is held are dropped.
module recepcao_face_serial #(
    parameter int TIMEOUT = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    recepcao_face_serial_if.slave  bus
);
    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ESPERA_MSB = 2'd0,
        ESPERA_LSB = 2'd1,
`ifdef RECEPCAO_CHECKSUM_EN
        ESPERA_CHK = 2'd2,
`endif
        COMPLETA   = 2'd3
    } estado_t;

    estado_t       estado, prox;
    logic [3:0]    idx;
    logic [7:0]    msb;
    logic [15:0]   cells [9];
    logic [CW-1:0] ocioso;
    logic [15:0]   q_r;
    logic          erro_r;
    logic [3:0]    rd_idx;

    logic carrega_msb, escreve, idx_inc, idx_clr, erro_set, contando, expira;

`ifdef RECEPCAO_CHECKSUM_EN
    logic [7:0] xor_acc;
`endif

    // The idle timer only runs while a face is partially received.
    always_comb begin
        contando = (estado == ESPERA_LSB) || ((estado == ESPERA_MSB) && (idx != 4'd0));
`ifdef RECEPCAO_CHECKSUM_EN
        if (estado == ESPERA_CHK) contando = 1'b1;
`endif
    end

    assign expira = contando && !bus.byte_valido && (ocioso == LIMITE);

    always_comb begin
        prox        = estado;
        carrega_msb = 1'b0;
        escreve     = 1'b0;
        idx_inc     = 1'b0;
        idx_clr     = 1'b0;
        erro_set    = 1'b0;
        case (estado)
            ESPERA_MSB: begin
                if (bus.byte_valido) begin
                    carrega_msb = 1'b1;
                    prox        = ESPERA_LSB;
                end else if (expira) begin
                    erro_set = 1'b1;
                    idx_clr  = 1'b1;
                end
            end
            ESPERA_LSB: begin
                if (bus.byte_valido) begin
                    escreve = 1'b1;
                    if (idx == 4'd8) begin
`ifdef RECEPCAO_CHECKSUM_EN
                        prox = ESPERA_CHK;
`else
                        prox = COMPLETA;
`endif
                    end else begin
                        idx_inc = 1'b1;
                        prox    = ESPERA_MSB;
                    end
                end else if (expira) begin
                    erro_set = 1'b1;
                    idx_clr  = 1'b1;
                    prox     = ESPERA_MSB;
                end
            end
`ifdef RECEPCAO_CHECKSUM_EN
            ESPERA_CHK: begin
                if (bus.byte_valido) begin
                    if (bus.dado_rx == xor_acc) begin
                        prox = COMPLETA;
                    end else begin
                        erro_set = 1'b1;
                        idx_clr  = 1'b1;
                        prox     = ESPERA_MSB;
                    end
                end else if (expira) begin
                    erro_set = 1'b1;
                    idx_clr  = 1'b1;
                    prox     = ESPERA_MSB;
                end
            end
`endif
            COMPLETA: begin
                if (bus.libera) begin
                    idx_clr = 1'b1;
                    prox    = ESPERA_MSB;
                end
            end
            default: prox = ESPERA_MSB;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ESPERA_MSB;
        else        estado <= prox;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            msb    <= '0;
            ocioso <= '0;
            erro_r <= 1'b0;
            for (int i = 0; i < 9; i++) cells[i] <= '0;
        end else begin
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 4'd1;

            if (carrega_msb) msb <= bus.dado_rx;
            if (escreve)     cells[idx] <= {msb, bus.dado_rx};

            if (!contando || bus.byte_valido || expira) ocioso <= '0;
            else                                        ocioso <= ocioso + 1'b1;

            if (erro_set)        erro_r <= 1'b1;
            else if (bus.libera) erro_r <= 1'b0;
        end
    end

`ifdef RECEPCAO_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       xor_acc <= '0;
        else if (idx_clr)                 xor_acc <= '0;
        else if (carrega_msb || escreve)  xor_acc <= xor_acc ^ bus.dado_rx;
    end
`endif

    // Row-major cell index; only meaningful when neither coordinate is 3.
    assign rd_idx = ({2'b00, bus.addr_linha} * 4'd3) + {2'b00, bus.addr_coluna};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                               q_r <= '0;
        else if ((bus.addr_linha == 2'd3) || (bus.addr_coluna == 2'd3)) q_r <= '0;
        else                                                      q_r <= cells[rd_idx];
    end

    assign bus.q           = q_r;
    assign bus.face_pronta = (estado == COMPLETA);
    assign bus.erro        = erro_r;
    assign bus.db_estado   = {1'b0, estado};
endmodule

// File: tb/tb_recepcao_face_serial.sv
// Directed bench for recepcao_face_serial with TIMEOUT=20; checksum steps compile only with RECEPCAO_CHECKSUM_EN.
module tb_recepcao_face_serial;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] tb_xor;

    recepcao_face_serial_if bus ();

    recepcao_face_serial #(.TIMEOUT(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valido = 1'b1;
        bus.dado_rx     = b;
        step();
        bus.byte_valido = 1'b0;
        tb_xor          = tb_xor ^ b;
    endtask

    task automatic send_pixels(input logic [15:0] base);
        logic [15:0] p;
        tb_xor = 8'h00;
        for (int i = 0; i < 9; i++) begin
            p = base + 16'(i);
            send_byte(p[15:8]);
            send_byte(p[7:0]);
        end
    endtask

    task automatic finish_face();
`ifdef RECEPCAO_CHECKSUM_EN
        chk("chk_state", {13'b0, bus.db_estado}, 16'd2);
        chk("chk_pronta_low", {15'b0, bus.face_pronta}, 16'd0);
        send_byte(tb_xor);
`endif
    endtask

    task automatic rd(input string tag, input logic [1:0] l, input logic [1:0] c, input logic [15:0] exp);
        bus.addr_linha  = l;
        bus.addr_coluna = c;
        step();
        chk(tag, bus.q, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.byte_valido = 1'b0;
        bus.dado_rx     = 8'h00;
        bus.libera      = 1'b0;
        bus.addr_linha  = 2'd0;
        bus.addr_coluna = 2'd0;
        tb_xor          = 8'h00;

        idle(3);
        chk("rst_q", bus.q, 16'h0000);
        chk("rst_pronta", {15'b0, bus.face_pronta}, 16'd0);
        chk("rst_erro", {15'b0, bus.erro}, 16'd0);
        chk("rst_estado", {13'b0, bus.db_estado}, 16'd0);
        reset = 1'b1;
        step();

        // Partial face, then asynchronous reset between clock edges.
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        chk("mid_estado", {13'b0, bus.db_estado}, 16'd1);
        #2 reset = 1'b0;
        #1 chk("async_rst_estado", {13'b0, bus.db_estado}, 16'd0);
        step();
        reset = 1'b1;
        rd("rst_read_11", 2'd1, 2'd1, 16'h0000);
        rd("rst_read_00", 2'd0, 2'd0, 16'h0000);

        // Face A: pixels 0001..0009.
        send_pixels(16'h0001);
        finish_face();
        chk("faceA_pronta", {15'b0, bus.face_pronta}, 16'd1);
        chk("faceA_estado", {13'b0, bus.db_estado}, 16'd3);
        chk("faceA_erro", {15'b0, bus.erro}, 16'd0);
        rd("faceA_22", 2'd2, 2'd2, 16'h0009);
        rd("faceA_01", 2'd0, 2'd1, 16'h0002);
        rd("faceA_10", 2'd1, 2'd0, 16'h0004);

        // Extra byte while complete is ignored.
        send_byte(8'hAA);
        send_byte(8'hAA);
        rd("frozen_00", 2'd0, 2'd0, 16'h0001);
        chk("frozen_pronta", {15'b0, bus.face_pronta}, 16'd1);
        bus.libera = 1'b1;
        step();
        bus.libera = 1'b0;
        chk("libera_pronta", {15'b0, bus.face_pronta}, 16'd0);
        chk("libera_estado", {13'b0, bus.db_estado}, 16'd0);
        rd("post_libera_22", 2'd2, 2'd2, 16'h0009);

        // New face overwrites from (0,0), then stalls after 5 bytes.
        send_byte(8'hBE);
        send_byte(8'hEF);
        rd("ovw_00", 2'd0, 2'd0, 16'hBEEF);
        rd("ovw_01_old", 2'd0, 2'd1, 16'h0002);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        idle(19);
        chk("to_before_erro", {15'b0, bus.erro}, 16'd0);
        chk("to_before_estado", {13'b0, bus.db_estado}, 16'd1);
        step();
        chk("to_erro", {15'b0, bus.erro}, 16'd1);
        chk("to_estado", {13'b0, bus.db_estado}, 16'd0);
        rd("to_keep_01", 2'd0, 2'd1, 16'h1234);

        // Face after timeout restarts at (0,0); erro sticks until libera.
        send_pixels(16'hC000);
        finish_face();
        chk("faceC_pronta", {15'b0, bus.face_pronta}, 16'd1);
        chk("faceC_erro", {15'b0, bus.erro}, 16'd1);
        rd("faceC_00", 2'd0, 2'd0, 16'hC000);
        rd("faceC_01", 2'd0, 2'd1, 16'hC001);
        rd("faceC_22", 2'd2, 2'd2, 16'hC008);
        rd("addr_30", 2'd3, 2'd0, 16'h0000);
        rd("addr_13", 2'd1, 2'd3, 16'h0000);

        // libera and byte together in COMPLETA: byte dropped.
        bus.libera      = 1'b1;
        bus.byte_valido = 1'b1;
        bus.dado_rx     = 8'h77;
        step();
        bus.libera      = 1'b0;
        bus.byte_valido = 1'b0;
        chk("simul_pronta", {15'b0, bus.face_pronta}, 16'd0);
        chk("simul_erro", {15'b0, bus.erro}, 16'd0);
        chk("simul_estado", {13'b0, bus.db_estado}, 16'd0);
        send_pixels(16'hD000);
        finish_face();
        rd("faceD_00", 2'd0, 2'd0, 16'hD000);
        rd("faceD_21", 2'd2, 2'd1, 16'hD007);
        bus.libera = 1'b1;
        step();
        bus.libera = 1'b0;

        // Byte arriving exactly at expiry wins over the timeout.
        send_byte(8'h01);
        idle(19);
        send_byte(8'h02);
        chk("race_erro", {15'b0, bus.erro}, 16'd0);
        chk("race_estado", {13'b0, bus.db_estado}, 16'd0);
        idle(20);
        chk("race_to_erro", {15'b0, bus.erro}, 16'd1);
        bus.libera = 1'b1;
        step();
        bus.libera = 1'b0;
        chk("libera_idle_erro", {15'b0, bus.erro}, 16'd0);
        chk("libera_idle_estado", {13'b0, bus.db_estado}, 16'd0);

`ifdef RECEPCAO_CHECKSUM_EN
        // Bad checksum: 18 bytes of 11 XOR to 00, send 01.
        for (int i = 0; i < 18; i++) send_byte(8'h11);
        send_byte(8'h01);
        chk("bad_chk_erro", {15'b0, bus.erro}, 16'd1);
        chk("bad_chk_pronta", {15'b0, bus.face_pronta}, 16'd0);
        chk("bad_chk_estado", {13'b0, bus.db_estado}, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
